algorithm_multi_vc: RTL and testbench

Per-input routing stage for the mesh AXI-Stream router, generalised to any number of virtual channels per direction. It decodes a routing header, picks an output direction by XY or YX dimension-order routing, and allocates a free virtual channel in that direction round-robin. It holds that channel for the whole packet and releases it on the TLAST handshake. One instance sits behind each router input port, ahead of the per-output arbiters.

---
 rtl/algorithm_multi_vc_pkg.sv | 27 ++
 rtl/algorithm_multi_vc_rr_select.sv | 30 +++
 rtl/algorithm_multi_vc.sv | 184 ++++++++++++++++++
 tb/tb_algorithm_multi_vc.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algorithm_multi_vc_pkg.sv
// Shared types and constants for the multi-VC routing stage: packet type field,
// direction and state encodings, and a width helper for VC indices.
package algorithm_multi_vc_pkg;

  localparam int PACKET_TYPE_WIDTH = 4;
  localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 4'hA;
  localparam int DIR_NUM = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } dir_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  // A single VC still needs a one-bit index so the pointer vectors are never zero-width.
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/algorithm_multi_vc_rr_select.sv
// Round-robin free-VC picker for one direction: scans from ptr upward with wrap
// and returns the first free VC index.
module vc_rr_select
  import algorithm_multi_vc_pkg::*;
#(
  parameter int VC_NUM = 2,
  localparam int VC_W = vc_width(VC_NUM)
) (
  input  logic [VC_NUM-1:0] free,
  input  logic [VC_W-1:0]   ptr,
  output logic              valid,
  output logic [VC_W-1:0]   idx
);

  logic [VC_W:0] cand_s;

  // Descending scan so the candidate nearest the pointer is the last one written.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int off = VC_NUM - 1; off >= 0; off--) begin
      cand_s = {1'b0, ptr} + (VC_W + 1)'(off);
      cand_s = (cand_s >= (VC_W + 1)'(VC_NUM)) ? cand_s - (VC_W + 1)'(VC_NUM) : cand_s;
      valid  = valid | free[cand_s[VC_W-1:0]];
      idx    = free[cand_s[VC_W-1:0]] ? cand_s[VC_W-1:0] : idx;
    end
  end

endmodule

// File: rtl/algorithm_multi_vc.sv
// Per-input routing stage: decodes a routing header, picks a direction by XY/YX
// dimension order, allocates a free VC round-robin and holds it until TLAST.
module algorithm_multi_vc
  import algorithm_multi_vc_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int VC_NUM              = 2,
  parameter int CHANNEL_NUMBER      = 5 * VC_NUM,
  parameter int MAX_ROUTERS_X       = 4,
  parameter int MAX_ROUTERS_Y       = 4,
  parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
  parameter int ROUTER_X            = 0,
  parameter int ROUTER_Y            = 0,
  parameter int ROUTING_MODE        = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_tvalid,
  output logic                                      in_tready,
  input  logic [DATA_WIDTH-1:0]                     in_tdata,
  input  logic                                      in_tlast,
  output logic [CHANNEL_NUMBER-1:0]                 out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]                 out_tready,
  output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] out_tdata,
  output logic [CHANNEL_NUMBER-1:0]                 out_tlast,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0]            target_x,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0]            target_y,
  input  logic [CHANNEL_NUMBER-1:0]                 ext_busy,
  output logic [CHANNEL_NUMBER-1:0]                 owned,
  output logic                                      drop
);

  localparam int VC_W = vc_width(VC_NUM);
  localparam int CH_W = $clog2(CHANNEL_NUMBER);
  localparam logic [MAX_ROUTERS_X_WIDTH-1:0] RX = MAX_ROUTERS_X_WIDTH'(ROUTER_X);
  localparam logic [MAX_ROUTERS_Y_WIDTH-1:0] RY = MAX_ROUTERS_Y_WIDTH'(ROUTER_Y);

  function automatic logic [CHANNEL_NUMBER-1:0] onehot(input logic [CH_W-1:0] i);
    return {{(CHANNEL_NUMBER - 1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
    return (v == VC_W'(VC_NUM - 1)) ? {VC_W{1'b0}} : v + 1'b1;
  endfunction

  state_t                      state_q, state_d;
  logic [CH_W-1:0]             sel_q, sel_d;
  logic [CHANNEL_NUMBER-1:0]   owned_q, owned_d;
  logic                        drop_q, drop_d;
  logic [VC_W-1:0]             rr_ptr_q [DIR_NUM];
  logic [VC_W-1:0]             rr_ptr_d [DIR_NUM];

  dir_t                        dir_s;
  logic                        x_eq_s, x_gt_s, y_eq_s, y_lt_s;
  logic                        hdr_s, vc_ok_s, stray_s, fwd_en_s, hs_s;
  logic [CHANNEL_NUMBER-1:0]   free_s;
  logic [DIR_NUM-1:0]          dir_valid_s;
  logic [VC_W-1:0]             dir_idx_s [DIR_NUM];
  logic [VC_W-1:0]             vc_s;
  logic [CH_W-1:0]             sel_s, ctrl_s;

  assign hdr_s  = (in_tdata[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
  assign x_eq_s = (target_x == RX);
  assign x_gt_s = (target_x > RX);
  assign y_eq_s = (target_y == RY);
  assign y_lt_s = (target_y < RY);
  assign free_s = ~(ext_busy | owned_q);

  // Dimension-order route; the mode only swaps which axis is resolved first.
  always_comb begin
    dir_s = LOCAL;
    if (ROUTING_MODE == 0) begin
      if (!x_eq_s)      dir_s = x_gt_s ? EAST : WEST;
      else if (!y_eq_s) dir_s = y_lt_s ? NORTH : SOUTH;
      else              dir_s = LOCAL;
    end else begin
      if (!y_eq_s)      dir_s = y_lt_s ? NORTH : SOUTH;
      else if (!x_eq_s) dir_s = x_gt_s ? EAST : WEST;
      else              dir_s = LOCAL;
    end
  end

  for (genvar d = 0; d < DIR_NUM; d++) begin : g_dir
    vc_rr_select #(.VC_NUM(VC_NUM)) u_sel (
      .free  (free_s[d*VC_NUM +: VC_NUM]),
      .ptr   (rr_ptr_q[d]),
      .valid (dir_valid_s[d]),
      .idx   (dir_idx_s[d])
    );
  end

  assign vc_ok_s = dir_valid_s[dir_s];
  assign vc_s    = dir_idx_s[dir_s];
  assign sel_s   = CH_W'(dir_s) * CH_W'(VC_NUM) + CH_W'(vc_s);

  // Flow control: ready follows the chosen output; strays are swallowed in IDLE.
  always_comb begin
    fwd_en_s  = 1'b0;
    ctrl_s    = sel_q;
    in_tready = 1'b0;
    stray_s   = 1'b0;
    if (!rst_n) begin
      fwd_en_s = 1'b0;
    end else if (state_q == FWD) begin
      fwd_en_s  = 1'b1;
      ctrl_s    = sel_q;
      in_tready = out_tready[sel_q];
    end else if (in_tvalid && hdr_s && vc_ok_s) begin
      fwd_en_s  = 1'b1;
      ctrl_s    = sel_s;
      in_tready = out_tready[sel_s];
    end else if (in_tvalid && !hdr_s) begin
      in_tready = 1'b1;
      stray_s   = 1'b1;
    end else begin
      in_tready = 1'b0;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      out_tvalid[c] = fwd_en_s && (ctrl_s == CH_W'(c)) && in_tvalid;
      out_tdata[c]  = (fwd_en_s && (ctrl_s == CH_W'(c))) ? in_tdata : '0;
      out_tlast[c]  = fwd_en_s && (ctrl_s == CH_W'(c)) && in_tlast;
    end
  end

  assign hs_s = in_tvalid && in_tready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    owned_d  = owned_q;
    rr_ptr_d = rr_ptr_q;
    drop_d   = stray_s;
    case (state_q)
      IDLE: begin
        if (hs_s && hdr_s && vc_ok_s) begin
          sel_d           = sel_s;
          rr_ptr_d[dir_s] = next_vc(vc_s);
          // A single-flit packet never holds its channel.
          if (!in_tlast) begin
            state_d = FWD;
            owned_d = onehot(sel_s);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FWD: begin
        if (hs_s && in_tlast) begin
          state_d = IDLE;
          owned_d = '0;
        end else begin
          state_d = FWD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      owned_q  <= '0;
      drop_q   <= 1'b0;
      rr_ptr_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owned_q  <= owned_d;
      drop_q   <= drop_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign owned = owned_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_algorithm_multi_vc.sv
// Bench for algorithm_multi_vc: an XY and a YX instance at router (1,1), directed
// scenarios plus randomized traffic checked against a packet-level model.
module tb_algorithm_multi_vc;
  import algorithm_multi_vc_pkg::*;

  localparam int DW = 32;
  localparam int VC = 2;
  localparam int CH = 10;
  localparam int RX = 1;
  localparam int RY = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   in_tvalid [2];
  logic                   in_tready [2];
  logic                   in_tlast  [2];
  logic [DW-1:0]          in_tdata  [2];
  logic [1:0]             tx [2];
  logic [1:0]             ty [2];
  logic [CH-1:0]          ext_busy   [2];
  logic [CH-1:0]          out_tready [2];
  logic [CH-1:0]          out_tvalid [2];
  logic [CH-1:0]          out_tlast  [2];
  logic [CH-1:0]          owned      [2];
  logic [CH-1:0][DW-1:0]  out_tdata  [2];
  logic                   drop [2];

  int n_cmp = 0;
  int n_bad = 0;

  algorithm_multi_vc #(.DATA_WIDTH(DW), .VC_NUM(VC), .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_MODE(0)) u_xy (
    .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid[0]), .in_tready(in_tready[0]),
    .in_tdata(in_tdata[0]), .in_tlast(in_tlast[0]), .out_tvalid(out_tvalid[0]),
    .out_tready(out_tready[0]), .out_tdata(out_tdata[0]), .out_tlast(out_tlast[0]),
    .target_x(tx[0]), .target_y(ty[0]), .ext_busy(ext_busy[0]), .owned(owned[0]), .drop(drop[0])
  );

  algorithm_multi_vc #(.DATA_WIDTH(DW), .VC_NUM(VC), .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_MODE(1)) u_yx (
    .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid[1]), .in_tready(in_tready[1]),
    .in_tdata(in_tdata[1]), .in_tlast(in_tlast[1]), .out_tvalid(out_tvalid[1]),
    .out_tready(out_tready[1]), .out_tdata(out_tdata[1]), .out_tlast(out_tlast[1]),
    .target_x(tx[1]), .target_y(ty[1]), .ext_busy(ext_busy[1]), .owned(owned[1]), .drop(drop[1])
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic v, input logic [3:0] typ, input logic [27:0] pl,
                       input logic last, input logic [1:0] x, input logic [1:0] y);
    in_tvalid[m] = v;
    in_tdata[m]  = {typ, pl};
    in_tlast[m]  = last;
    tx[m]        = x;
    ty[m]        = y;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      drive(m, 1'b0, 4'h0, 28'h0, 1'b0, 2'd0, 2'd0);
      out_tready[m] = '1;
      ext_busy[m]   = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [CH-1:0] ch_bit(input int c);
    logic [CH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int m_sel   [2];
  bit m_fwd   [2];
  int m_owned [2];
  int m_rr    [2][5];
  bit m_drop  [2];

  function automatic int route(input int mode, input int x, input int y);
    int dx, dy;
    dx = x - RX;
    dy = y - RY;
    if (mode == 0) begin
      if (dx > 0) return 2;
      if (dx < 0) return 4;
      if (dy < 0) return 1;
      if (dy > 0) return 3;
      return 0;
    end
    if (dy < 0) return 1;
    if (dy > 0) return 3;
    if (dx > 0) return 2;
    if (dx < 0) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sel[m] = 0; m_fwd[m] = 1'b0; m_owned[m] = -1; m_drop[m] = 1'b0;
      for (int d = 0; d < 5; d++) m_rr[m][d] = 0;
    end
  endtask

  task automatic model_eval(input int m, output int ch, output bit rdy, output bit stray);
    int d, v, c;
    ch = -1; rdy = 1'b0; stray = 1'b0;
    if (!rst_n) return;
    if (m_fwd[m]) begin
      ch  = m_sel[m];
      rdy = out_tready[m][ch];
    end else if (in_tvalid[m]) begin
      if (in_tdata[m][DW-1 -: 4] == ROUTING_HEADER) begin
        d = route(m, int'(tx[m]), int'(ty[m]));
        for (int k = 0; k < VC; k++) begin
          v = (m_rr[m][d] + k) % VC;
          c = d * VC + v;
          if (ch < 0 && !ext_busy[m][c] && m_owned[m] != c) ch = c;
        end
        if (ch >= 0) rdy = out_tready[m][ch];
      end else begin
        rdy = 1'b1;
        stray = 1'b1;
      end
    end
  endtask

  task automatic model_commit(input int m, input int ch, input bit rdy, input bit stray);
    bit hs;
    hs = in_tvalid[m] && rdy;
    if (!rst_n) begin
      m_sel[m] = 0; m_fwd[m] = 1'b0; m_owned[m] = -1; m_drop[m] = 1'b0;
      for (int d = 0; d < 5; d++) m_rr[m][d] = 0;
    end else begin
      m_drop[m] = stray && hs;
      if (!m_fwd[m] && ch >= 0 && hs) begin
        m_sel[m] = ch;
        m_rr[m][ch / VC] = ((ch % VC) + 1) % VC;
        if (!in_tlast[m]) begin
          m_fwd[m] = 1'b1;
          m_owned[m] = ch;
        end
      end else if (m_fwd[m] && hs && in_tlast[m]) begin
        m_fwd[m] = 1'b0;
        m_owned[m] = -1;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) drive(m, 1'b1, ROUTING_HEADER, 28'h1234, 1'b0, 2'd3, 2'd0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (in_tready[m] !== 1'b0) begin n_bad++; $display("FAIL reset_tready[%0d]: got %b want 0", m, in_tready[m]); end
      n_cmp++;
      if (out_tvalid[m] !== '0) begin n_bad++; $display("FAIL reset_tvalid[%0d]: got %b want 0", m, out_tvalid[m]); end
    end
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (owned[m] !== '0) begin n_bad++; $display("FAIL reset_owned[%0d]: got %b want 0", m, owned[m]); end
      n_cmp++;
      if (drop[m] !== 1'b0) begin n_bad++; $display("FAIL reset_drop[%0d]: got %b want 0", m, drop[m]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_local_single();
    do_reset();
    drive(0, 1'b1, ROUTING_HEADER, 28'h0ABCDEF, 1'b1, 2'd1, 2'd1);
    @(negedge clk);
    n_cmp++;
    if (out_tvalid[0] !== ch_bit(0)) begin n_bad++; $display("FAIL local_tvalid: got %b want %b", out_tvalid[0], ch_bit(0)); end
    n_cmp++;
    if (out_tdata[0][0] !== {ROUTING_HEADER, 28'h0ABCDEF}) begin n_bad++; $display("FAIL local_tdata: got %h", out_tdata[0][0]); end
    n_cmp++;
    if (in_tready[0] !== 1'b1) begin n_bad++; $display("FAIL local_tready: got %b want 1", in_tready[0]); end
    tick();
    idle_all();
    n_cmp++;
    if (owned[0] !== '0) begin n_bad++; $display("FAIL local_owned: got %b want 0", owned[0]); end
    // The pointer for LOCAL moved to 1, so the next local packet lands on VC1.
    drive(0, 1'b1, ROUTING_HEADER, 28'h1, 1'b1, 2'd1, 2'd1);
    @(negedge clk);
    n_cmp++;
    if (out_tvalid[0] !== ch_bit(1)) begin n_bad++; $display("FAIL local_rr: got %b want %b", out_tvalid[0], ch_bit(1)); end
    tick();
    idle_all();
  endtask

  task automatic test_xy_yx();
    int exp_ch;
    logic [CH-1:0] exp_own;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      exp_ch = (m == 0) ? 4 : 2;
      for (int f = 0; f < 3; f++) begin
        if (f == 0) drive(m, 1'b1, ROUTING_HEADER, 28'(f), 1'b0, 2'd3, 2'd0);
        else drive(m, 1'b1, 4'($urandom_range(0, 15)), 28'($urandom), f == 2, 2'($urandom), 2'($urandom));
        @(negedge clk);
        n_cmp++;
        if (out_tvalid[m] !== ch_bit(exp_ch)) begin n_bad++; $display("FAIL route_tvalid[%0d] flit %0d: got %b want %b", m, f, out_tvalid[m], ch_bit(exp_ch)); end
        tick();
        exp_own = (f < 2) ? ch_bit(exp_ch) : '0;
        n_cmp++;
        if (owned[m] !== exp_own) begin n_bad++; $display("FAIL route_owned[%0d] flit %0d: got %b want %b", m, f, owned[m], exp_own); end
      end
      idle_all();
    end
  endtask

  task automatic test_rr_exhaust();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 2; f++) begin
        drive(0, 1'b1, (f == 0) ? ROUTING_HEADER : 4'h2, 28'(p), f == 1, 2'd3, 2'd1);
        @(negedge clk);
        n_cmp++;
        if (out_tvalid[0] !== ch_bit(4 + p)) begin n_bad++; $display("FAIL rr_pkt%0d: got %b want %b", p, out_tvalid[0], ch_bit(4 + p)); end
        tick();
      end
    end
    idle_all();
    ext_busy[0] = 10'b0000110000;
    drive(0, 1'b1, ROUTING_HEADER, 28'h77, 1'b1, 2'd3, 2'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_tready[0] !== 1'b0) begin n_bad++; $display("FAIL stall_tready: got %b want 0", in_tready[0]); end
      n_cmp++;
      if (out_tvalid[0] !== '0) begin n_bad++; $display("FAIL stall_tvalid: got %b want 0", out_tvalid[0]); end
      tick();
    end
    ext_busy[0] = 10'b0000100000;
    @(negedge clk);
    n_cmp++;
    if (in_tready[0] !== 1'b1) begin n_bad++; $display("FAIL release_tready: got %b want 1", in_tready[0]); end
    n_cmp++;
    if (out_tvalid[0] !== ch_bit(4)) begin n_bad++; $display("FAIL release_tvalid: got %b want %b", out_tvalid[0], ch_bit(4)); end
    tick();
    idle_all();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] sent [5];
    logic [DW-1:0] got [$];
    int idx, stall_cnt;
    bit exp_rdy;
    do_reset();
    for (int i = 0; i < 5; i++) sent[i] = {(i == 0) ? ROUTING_HEADER : 4'h5, 28'($urandom)};
    idx = 0;
    stall_cnt = 0;
    for (int cyc = 0; cyc < 30 && idx < 5; cyc++) begin
      in_tvalid[0] = 1'b1;
      in_tdata[0]  = sent[idx];
      in_tlast[0]  = (idx == 4);
      tx[0] = 2'd2;
      ty[0] = 2'd1;
      exp_rdy = !(idx == 2 && stall_cnt < 3);
      out_tready[0] = exp_rdy ? '1 : '0;
      if (!exp_rdy) stall_cnt++;
      @(negedge clk);
      n_cmp++;
      if (in_tready[0] !== exp_rdy) begin n_bad++; $display("FAIL bp_tready cyc %0d: got %b want %b", cyc, in_tready[0], exp_rdy); end
      n_cmp++;
      if (out_tvalid[0] !== ch_bit(4)) begin n_bad++; $display("FAIL bp_tvalid cyc %0d: got %b want %b", cyc, out_tvalid[0], ch_bit(4)); end
      if (out_tvalid[0][4] && out_tready[0][4]) got.push_back(out_tdata[0][4]);
      tick();
      if (exp_rdy) idx++;
    end
    n_cmp++;
    if (got.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== sent[i]) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], sent[i]); end
    end
    idle_all();
  endtask

  task automatic test_stray();
    do_reset();
    drive(0, 1'b1, 4'h3, 28'h55, 1'b0, 2'd3, 2'd3);
    @(negedge clk);
    n_cmp++;
    if (in_tready[0] !== 1'b1) begin n_bad++; $display("FAIL stray_tready: got %b want 1", in_tready[0]); end
    n_cmp++;
    if (out_tvalid[0] !== '0) begin n_bad++; $display("FAIL stray_tvalid: got %b want 0", out_tvalid[0]); end
    tick();
    idle_all();
    n_cmp++;
    if (drop[0] !== 1'b1) begin n_bad++; $display("FAIL stray_drop: got %b want 1", drop[0]); end
    tick();
    n_cmp++;
    if (drop[0] !== 1'b0) begin n_bad++; $display("FAIL stray_drop_end: got %b want 0", drop[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1'b1, ROUTING_HEADER, 28'h9, 1'b0, 2'd3, 2'd1);
    tick();
    n_cmp++;
    if (owned[0] !== ch_bit(4)) begin n_bad++; $display("FAIL mid_owned: got %b want %b", owned[0], ch_bit(4)); end
    drive(0, 1'b1, 4'h6, 28'hA, 1'b0, 2'd0, 2'd0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_tready[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tready: got %b want 0", in_tready[0]); end
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (owned[0] !== '0) begin n_bad++; $display("FAIL mid_freed: got %b want 0", owned[0]); end
    @(negedge clk);
    n_cmp++;
    if (in_tready[0] !== 1'b1 || out_tvalid[0] !== '0) begin n_bad++; $display("FAIL mid_trailing: got rdy %b vld %b want 1 and 0", in_tready[0], out_tvalid[0]); end
    tick();
    n_cmp++;
    if (drop[0] !== 1'b1) begin n_bad++; $display("FAIL mid_drop: got %b want 1", drop[0]); end
    drive(0, 1'b1, ROUTING_HEADER, 28'hB, 1'b1, 2'd1, 2'd0);
    @(negedge clk);
    n_cmp++;
    if (out_tvalid[0] !== ch_bit(2)) begin n_bad++; $display("FAIL mid_next_hdr: got %b want %b", out_tvalid[0], ch_bit(2)); end
    tick();
    idle_all();
  endtask

  task automatic test_random();
    int rem [2];
    int ch  [2];
    bit rdy [2];
    bit str [2];
    int r, len;
    logic [CH-1:0] exp_v, exp_o;
    do_reset();
    model_reset();
    rem[0] = 0;
    rem[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!in_tvalid[m]) begin
          if (rem[m] > 0) begin
            drive(m, 1'b1, 4'($urandom_range(0, 15)), 28'($urandom), rem[m] == 1, 2'($urandom), 2'($urandom));
          end else begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
              len = $urandom_range(1, 4);
              rem[m] = len;
              drive(m, 1'b1, ROUTING_HEADER, 28'($urandom), len == 1, 2'($urandom), 2'($urandom));
            end else if (r < 70) begin
              drive(m, 1'b1, 4'($urandom_range(0, 9)), 28'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
            end else begin
              in_tvalid[m] = 1'b0;
            end
          end
        end
        out_tready[m] = CH'($urandom) | CH'($urandom);
        ext_busy[m]   = CH'($urandom) & CH'($urandom) & CH'($urandom);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        model_eval(m, ch[m], rdy[m], str[m]);
        exp_v = (ch[m] >= 0 && in_tvalid[m]) ? ch_bit(ch[m]) : '0;
        exp_o = (m_owned[m] >= 0) ? ch_bit(m_owned[m]) : '0;
        n_cmp++;
        if (in_tready[m] !== rdy[m]) begin n_bad++; $display("FAIL rnd_tready[%0d] cyc %0d: got %b want %b", m, cyc, in_tready[m], rdy[m]); end
        n_cmp++;
        if (out_tvalid[m] !== exp_v) begin n_bad++; $display("FAIL rnd_tvalid[%0d] cyc %0d: got %b want %b", m, cyc, out_tvalid[m], exp_v); end
        if (ch[m] >= 0 && in_tvalid[m]) begin
          n_cmp++;
          if (out_tdata[m][ch[m]] !== in_tdata[m] || out_tlast[m][ch[m]] !== in_tlast[m]) begin
            n_bad++; $display("FAIL rnd_payload[%0d] cyc %0d: got %h/%b want %h/%b", m, cyc, out_tdata[m][ch[m]], out_tlast[m][ch[m]], in_tdata[m], in_tlast[m]);
          end
        end
        n_cmp++;
        if (owned[m] !== exp_o) begin n_bad++; $display("FAIL rnd_owned[%0d] cyc %0d: got %b want %b", m, cyc, owned[m], exp_o); end
        n_cmp++;
        if (drop[m] !== m_drop[m]) begin n_bad++; $display("FAIL rnd_drop[%0d] cyc %0d: got %b want %b", m, cyc, drop[m], m_drop[m]); end
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_commit(m, ch[m], rdy[m], str[m]);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (in_tvalid[m] && rdy[m]) begin
          in_tvalid[m] = 1'b0;
          if (rem[m] > 0) rem[m]--;
        end
      end
    end
    idle_all();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_local_single();
    test_xy_yx();
    test_rr_exhaust();
    test_backpressure();
    test_stray();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
